// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO responder: register offsets,
// response state encoding and board I/O counts.
package gpio_pkg;

  localparam int NUM_BTN = 5;
  localparam int NUM_LED = 4;

  localparam logic [2:0] OFS_ID        = 3'd0;
  localparam logic [2:0] OFS_CLK_FREQ  = 3'd1;
  localparam logic [2:0] OFS_LED       = 3'd2;
  localparam logic [2:0] OFS_BTN_STATE = 3'd3;
  localparam logic [2:0] OFS_BTN_EDGE  = 3'd4;
  localparam logic [2:0] OFS_IE        = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } resp_state_t;

  // Word offsets 0x18 and 0x1C are holes in the map and answer with ERROR.
  function automatic logic ofs_mapped(input logic [2:0] ofs);
    return (ofs <= OFS_IE);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One button: 2-flop synchronizer, optional inversion, stability counter and
// accepted state. rise is high in the cycle whose edge accepts a new press.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic state,
  output logic rise
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             state_r;
  logic             level_s;
  logic             settle_s;

  // Metastability guard for the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

  assign level_s  = BTN_ACTIVE_LOW ? ~sync_r[1] : sync_r[1];
  assign settle_s = (level_s != state_r) && (cnt_r == CNT_LAST);

  // Any agreement with the accepted state restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= 1'b0;
    end else if (level_s == state_r) begin
      cnt_r   <= {CNT_W{1'b0}};
    end else if (settle_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= level_s;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  assign state = state_r;
  assign rise  = settle_s & level_s;

endmodule

// File: rtl/ahb_lite_gpio.sv
// AHB-Lite responder exposing LEDs, debounced buttons with edge capture and
// interrupt, plus read-only ID and core-clock frequency registers.
module ahb_lite_gpio
  import gpio_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ        = 32'd27_000_000,
  parameter logic [31:0] GPIO_ID         = 32'h4750_0001,
  parameter int          DEBOUNCE_CYCLES = 270_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter bit          LED_ACTIVE_LOW  = 1'b1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [31:0]         HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic [31:0]         HRDATA,
  output logic                HRESP,
  input  logic [NUM_BTN-1:0]  BTN,
  output logic [NUM_LED-1:0]  LED,
  output logic                IRQ
);

  logic               accept_s;
  logic               dp_valid_r;
  logic               dp_write_r;
  logic               dp_lane0_r;
  logic [2:0]         dp_ofs_r;
  logic               wr_en_s;
  logic [NUM_BTN-1:0] w1c_s;
  resp_state_t        state_r;
  logic               hreadyout_r;
  logic               hresp_r;
  logic [NUM_LED-1:0] led_r;
  logic [NUM_BTN-1:0] btn_ie_r;
  logic [NUM_BTN-1:0] btn_edge_r;
  logic [NUM_BTN-1:0] btn_state_s;
  logic [NUM_BTN-1:0] btn_rise_s;
  logic               irq_r;
  logic [31:0]        rdata_s;
  logic               unused_s;

  assign accept_s = HSEL & HTRANS[1] & HREADY;
  assign unused_s = &{1'b0, HADDR[31:5], HTRANS[0], HSIZE, HWDATA[31:NUM_BTN]};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .btn   (BTN[i]),
      .state (btn_state_s[i]),
      .rise  (btn_rise_s[i])
    );
  end

  // Address-phase capture; the data phase is the following cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_lane0_r <= 1'b0;
      dp_ofs_r   <= 3'd0;
    end else begin
      dp_valid_r <= accept_s;
      if (accept_s) begin
        dp_write_r <= HWRITE;
        dp_lane0_r <= (HADDR[1:0] == 2'b00);
        dp_ofs_r   <= HADDR[4:2];
      end
    end
  end

  // Response FSM: an unmapped access gets the two-cycle AHB ERROR sequence.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ERR2: begin
          if (accept_s && !ofs_mapped(HADDR[4:2])) begin
            state_r     <= ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= 1'b1;
          end else begin
            state_r     <= IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
          end
        end
        ERR1: begin
          state_r     <= ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_s = dp_valid_r & dp_write_r & dp_lane0_r;
  assign w1c_s   = (wr_en_s && (dp_ofs_r == OFS_BTN_EDGE)) ? HWDATA[NUM_BTN-1:0]
                                                           : {NUM_BTN{1'b0}};

  // Register file; a fresh press outranks a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      led_r      <= {NUM_LED{1'b0}};
      btn_ie_r   <= {NUM_BTN{1'b0}};
      btn_edge_r <= {NUM_BTN{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      irq_r      <= |(btn_edge_r & btn_ie_r);
      btn_edge_r <= (btn_edge_r & ~w1c_s) | btn_rise_s;
      if (wr_en_s && (dp_ofs_r == OFS_LED)) begin
        led_r <= HWDATA[NUM_LED-1:0];
      end
      if (wr_en_s && (dp_ofs_r == OFS_IE)) begin
        btn_ie_r <= HWDATA[NUM_BTN-1:0];
      end
    end
  end

  // Read mux, live from the registers so a write is visible to the next read.
  always_comb begin
    rdata_s = 32'd0;
    if (dp_valid_r && !dp_write_r) begin
      case (dp_ofs_r)
        OFS_ID:        rdata_s = GPIO_ID;
        OFS_CLK_FREQ:  rdata_s = CLK_FREQ;
        OFS_LED:       rdata_s = {{(32-NUM_LED){1'b0}}, led_r};
        OFS_BTN_STATE: rdata_s = {{(32-NUM_BTN){1'b0}}, btn_state_s};
        OFS_BTN_EDGE:  rdata_s = {{(32-NUM_BTN){1'b0}}, btn_edge_r};
        OFS_IE:        rdata_s = {{(32-NUM_BTN){1'b0}}, btn_ie_r};
        default:       rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;
  assign HRDATA    = rdata_s;
  assign LED       = LED_ACTIVE_LOW ? ~led_r : led_r;
  assign IRQ       = irq_r;

endmodule

// File: tb/tb_ahb_lite_gpio.sv
// Self-checking bench for ahb_lite_gpio: directed scenarios plus random bus
// and button traffic against a cycle-level behavioural model.
module tb_ahb_lite_gpio;

  localparam int DC = 8;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic [4:0]  btn;
  logic [3:0]  led;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [3:0]  m_led;
  logic [4:0]  m_ie, m_edge, m_st;
  logic        m_irq;
  logic        m_acc, m_wr, m_lane0;
  logic [2:0]  m_ofs;
  logic [4:0]  hist[$];

  ahb_lite_gpio #(.DEBOUNCE_CYCLES(DC)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout),
    .HREADYOUT(hreadyout), .HRDATA(hrdata), .HRESP(hresp), .BTN(btn), .LED(led), .IRQ(irq)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] o);
    case (o)
      3'd0:    return 32'h4750_0001;
      3'd1:    return 32'd27_000_000;
      3'd2:    return {28'd0, m_led};
      3'd3:    return {27'd0, m_st};
      3'd4:    return {27'd0, m_edge};
      3'd5:    return {27'd0, m_ie};
      default: return 32'd0;
    endcase
  endfunction

  // Model: a button level is accepted once DC synchronized samples agree.
  initial begin
    logic [4:0] rise, w1c;
    logic       v, stable;
    int         n;
    forever begin
      @(posedge hclk);
      if (!hresetn) begin
        m_led = 4'd0; m_ie = 5'd0; m_edge = 5'd0; m_st = 5'd0; m_irq = 1'b0;
        m_acc = 1'b0; m_wr = 1'b0; m_lane0 = 1'b0; m_ofs = 3'd0;
        hist = '{5'h1F, 5'h1F};
      end else begin
        rise = 5'd0; w1c = 5'd0;
        hist.push_back(~btn);
        n = hist.size();
        if (n >= DC + 2) begin
          for (int i = 0; i < 5; i++) begin
            v = hist[n-3][i];
            stable = 1'b1;
            for (int k = 0; k < DC; k++) if (hist[n-3-k][i] != v) stable = 1'b0;
            if (stable && (v != m_st[i])) begin
              m_st[i] = v;
              rise[i] = v;
            end
          end
        end
        if (n > DC + 6) void'(hist.pop_front());
        m_irq = |(m_edge & m_ie);
        if (m_acc && m_wr && m_lane0) begin
          case (m_ofs)
            3'd2:    m_led = hwdata[3:0];
            3'd4:    w1c   = hwdata[4:0];
            3'd5:    m_ie  = hwdata[4:0];
            default: ;
          endcase
        end
        m_edge = (m_edge & ~w1c) | rise;
        m_acc   = hsel & htrans[1] & hreadyout;
        m_wr    = hwrite;
        m_ofs   = haddr[4:2];
        m_lane0 = (haddr[1:0] == 2'b00);
      end
    end
  end

  // Pins are compared with the model every cycle outside reset.
  initial begin
    forever begin
      @(posedge hclk);
      #1;
      if (hresetn) begin
        chk("led_pins", {28'd0, led}, {28'd0, ~m_led});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
  endtask

  // One complete transfer from an idle bus; response and read data are checked.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, output logic [31:0] rd);
    logic [2:0] o;
    o = addr[4:2];
    addr_phase(wr, addr, size);
    step();
    idle_bus();
    hwdata = wdata;
    rd = hrdata;
    if (o >= 3'd6) begin
      chk("err1_ready", {31'd0, hreadyout}, 32'd0);
      chk("err1_resp", {31'd0, hresp}, 32'd1);
      chk("err1_rdata", hrdata, 32'd0);
      step();
      chk("err2_ready", {31'd0, hreadyout}, 32'd1);
      chk("err2_resp", {31'd0, hresp}, 32'd1);
      chk("err2_rdata", hrdata, 32'd0);
      step();
      chk("post_err_ready", {31'd0, hreadyout}, 32'd1);
      chk("post_err_resp", {31'd0, hresp}, 32'd0);
    end else begin
      chk("okay_ready", {31'd0, hreadyout}, 32'd1);
      chk("okay_resp", {31'd0, hresp}, 32'd0);
      if (!wr) chk("rdata", hrdata, m_read(o));
      step();
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        found;
    int unsigned r;
    int          b;
    logic [31:0] a;

    hresetn = 1'b0; btn = 5'h1F; hwdata = 32'd0; haddr = 32'd0; hsize = 3'd2;
    idle_bus();
    repeat (3) step();
    chk("rst_ready", {31'd0, hreadyout}, 32'd1);
    chk("rst_resp", {31'd0, hresp}, 32'd0);
    chk("rst_rdata", hrdata, 32'd0);
    chk("rst_led", {28'd0, led}, 32'hF);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    hresetn = 1'b1;
    repeat (4) step();

    xfer(1'b0, 32'h00, 32'd0, 3'd2, rd); chk("id_value", rd, 32'h4750_0001);
    xfer(1'b0, 32'h04, 32'd0, 3'd2, rd); chk("clk_value", rd, 32'd27_000_000);

    // Back-to-back write then read of LED
    addr_phase(1'b1, 32'h08, 3'd2);
    step();
    hwdata = 32'h5;
    addr_phase(1'b0, 32'h08, 3'd2);
    step();
    idle_bus();
    chk("b2b_rdata", hrdata, 32'h5);
    chk("b2b_ready", {31'd0, hreadyout}, 32'd1);
    step();
    chk("led_pins_a", {28'd0, led}, 32'hA);

    // Debounce latency on BTN[2], polled with pipelined reads of BTN_STATE
    btn = 5'h1B;
    addr_phase(1'b0, 32'h0C, 3'd2);
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!found) begin
        step();
        if (hrdata[2]) begin found = 1'b1; lat = k; end
      end
    end
    idle_bus();
    step();
    chk("db_latency", lat, 32'd10);
    repeat (8) step();
    xfer(1'b0, 32'h0C, 32'd0, 3'd2, rd); chk("btn_state", rd, 32'h4);
    xfer(1'b0, 32'h10, 32'd0, 3'd2, rd); chk("btn_edge", rd, 32'h4);
    btn = 5'h1F;
    repeat (15) step();
    btn = 5'h1B;
    repeat (5) step();
    btn = 5'h1F;
    repeat (15) step();
    xfer(1'b0, 32'h0C, 32'd0, 3'd2, rd); chk("glitch_state", rd, 32'h0);

    // Interrupt path and write-1-to-clear
    xfer(1'b1, 32'h10, 32'h4, 3'd2, rd);
    xfer(1'b0, 32'h10, 32'd0, 3'd2, rd); chk("edge_cleared", rd, 32'h0);
    xfer(1'b1, 32'h14, 32'h4, 3'd2, rd);
    step();
    chk("irq_idle", {31'd0, irq}, 32'd0);
    btn = 5'h1B;
    repeat (14) step();
    chk("irq_set", {31'd0, irq}, 32'd1);
    xfer(1'b1, 32'h10, 32'h4, 3'd2, rd);
    chk("irq_hold_after_w1c", {31'd0, irq}, 32'd1);
    step();
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    btn = 5'h1F;
    repeat (15) step();

    // Press whose acceptance coincides with the W1C write: set wins
    btn = 5'h1B;
    repeat (8) step();
    addr_phase(1'b1, 32'h10, 3'd2);
    step();
    idle_bus();
    hwdata = 32'h4;
    step();
    xfer(1'b0, 32'h10, 32'd0, 3'd2, rd); chk("w1c_set_wins", rd, 32'h4);
    xfer(1'b1, 32'h10, 32'h1F, 3'd2, rd);
    btn = 5'h1F;
    repeat (15) step();

    // Error responses, single and back-to-back
    xfer(1'b0, 32'h18, 32'd0, 3'd2, rd);
    addr_phase(1'b0, 32'h18, 3'd2);
    step();
    idle_bus();
    chk("dbl_err1a_ready", {31'd0, hreadyout}, 32'd0);
    chk("dbl_err1a_resp", {31'd0, hresp}, 32'd1);
    step();
    chk("dbl_err2a_ready", {31'd0, hreadyout}, 32'd1);
    chk("dbl_err2a_resp", {31'd0, hresp}, 32'd1);
    addr_phase(1'b0, 32'h1C, 3'd2);
    step();
    idle_bus();
    chk("dbl_err1b_ready", {31'd0, hreadyout}, 32'd0);
    chk("dbl_err1b_resp", {31'd0, hresp}, 32'd1);
    step();
    chk("dbl_err2b_ready", {31'd0, hreadyout}, 32'd1);
    chk("dbl_err2b_resp", {31'd0, hresp}, 32'd1);
    chk("dbl_err2b_rdata", hrdata, 32'd0);
    step();
    chk("dbl_idle_ready", {31'd0, hreadyout}, 32'd1);
    chk("dbl_idle_resp", {31'd0, hresp}, 32'd0);

    // Byte write on lane 1 must not touch LED
    xfer(1'b1, 32'h09, 32'hFFFF_FFFF, 3'd0, rd);
    xfer(1'b0, 32'h08, 32'd0, 3'd2, rd); chk("byte_lane1_ignored", rd, 32'h5);

    // Reset during a write data phase
    addr_phase(1'b1, 32'h08, 3'd2);
    step();
    idle_bus();
    hwdata = 32'h3;
    hresetn = 1'b0;
    #1;
    chk("midrst_led", {28'd0, led}, 32'hF);
    chk("midrst_ready", {31'd0, hreadyout}, 32'd1);
    chk("midrst_resp", {31'd0, hresp}, 32'd0);
    chk("midrst_rdata", hrdata, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    repeat (2) step();
    hresetn = 1'b1;
    repeat (4) step();
    xfer(1'b0, 32'h08, 32'd0, 3'd2, rd); chk("midrst_write_dropped", rd, 32'h0);

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        b = $urandom_range(0, 4);
        btn[b] = ~btn[b];
        repeat ($urandom_range(1, 20)) step();
      end else if (r < 9) begin
        a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
        xfer(1'($urandom_range(0, 1)), a, $urandom, 3'd2, rd);
      end else begin
        repeat ($urandom_range(1, 12)) step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
